video_timing_gen: RTL

- Free-running raster timing generator; the upstream stage that drives the foreground/background scanline renderers and the VGA output pins.
- Produces pixel coordinates in game space (current and one-clock-ahead), horizontal and vertical sync, a game-area visible flag, a frame counter, and a level vblank interrupt with acknowledge for the CPU interface.
- Runs at the GPU pixel clock (half the VGA dot rate; one clock per horizontal pixel position).

---
 rtl/video_timing_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster timing generator for the scanline renderers and VGA pins
//
// Purpose: counts pixel clocks and raw lines, folds raw lines into game rows
// (LINE_REPEAT raw lines per row), and produces sync, visibility, blanking,
// a completed-frame counter and a level vblank interrupt.
//
// Ports:
//   gpu_clk      in   pixel clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   irq_enable   in   permits setting vblank_irq on the vblank event
//   irq_ack      in   clears vblank_irq (already synchronous to gpu_clk)
//   current_x    out  horizontal counter 0..H_TOTAL-1
//   current_y    out  game row (raw_line / LINE_REPEAT)
//   next_x       out  current_x after the next edge
//   next_y       out  current_y after the next edge
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   visible      out  inside the GAME_W x GAME_H area
//   vblank       out  raw_line >= V_VISIBLE
//   vblank_irq   out  level interrupt request
//   frame_count  out  completed-frame counter, wraps 255 -> 0
module video_timing_gen #(
  parameter int H_VISIBLE   = 320,
  parameter int H_FRONT     = 8,
  parameter int H_SYNC      = 48,
  parameter int H_BACK      = 24,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LINE_REPEAT = 2,
  parameter int GAME_W      = 256,
  parameter int GAME_H      = 240
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic       irq_enable,
  input  logic       irq_ack,
  output logic [8:0] current_x,
  output logic [8:0] current_y,
  output logic [8:0] next_x,
  output logic [8:0] next_y,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       vblank,
  output logic       vblank_irq,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int REP_W   = (LINE_REPEAT < 2) ? 1 : $clog2(LINE_REPEAT);

  // Ten-bit compare constants so bounds equal to 512 do not truncate.
  localparam logic [8:0]       H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(LINE_REPEAT - 1);
  localparam logic [9:0]       HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]       HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]       GW       = 10'(GAME_W);
  localparam logic [9:0]       GH       = 10'(GAME_H);

  if (LINE_REPEAT < 2) begin : g_err_rep
    $error("LINE_REPEAT must be at least 2");
  end
  if (H_TOTAL > 512) begin : g_err_htot
    $error("H_TOTAL must not exceed 512");
  end
  if ((V_TOTAL + LINE_REPEAT - 1) / LINE_REPEAT > 512) begin : g_err_rows
    $error("game row count must not exceed 512");
  end
  if (GAME_W > H_VISIBLE) begin : g_err_gw
    $error("GAME_W must not exceed H_VISIBLE");
  end
  if (GAME_H * LINE_REPEAT > V_VISIBLE) begin : g_err_gh
    $error("GAME_H * LINE_REPEAT must not exceed V_VISIBLE");
  end

  logic [8:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       raw_line_q, raw_line_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [8:0]       y_cnt_q, y_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vblank_irq_q, vblank_irq_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             vblank_evt;

  always_comb begin
    h_cnt_d    = h_cnt_q + 9'd1;
    raw_line_d = raw_line_q;
    rep_cnt_d  = rep_cnt_q;
    y_cnt_d    = y_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 9'd0;
      if (raw_line_q == V_LAST) begin
        // End of frame resets the row fold even mid-repeat, so an odd
        // V_TOTAL leaves the last row one raw line tall.
        raw_line_d = 10'd0;
        rep_cnt_d  = '0;
        y_cnt_d    = 9'd0;
      end else begin
        raw_line_d = raw_line_q + 10'd1;
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          y_cnt_d   = y_cnt_q + 9'd1;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
    end

    // Syncs decode the next-state counters so the registered pins line up
    // with current_x / raw_line without a combinational glitch path.
    hsync_d = !(({1'b0, h_cnt_d} >= HS_START) && ({1'b0, h_cnt_d} < HS_END));
    vsync_d = !((raw_line_d >= VS_START) && (raw_line_d < VS_END));

    // h_cnt_d is zero only on a line wrap, so this is a single edge per frame.
    vblank_evt    = (h_cnt_d == 9'd0) && (raw_line_d == V_VIS);
    frame_count_d = frame_count_q + {7'd0, vblank_evt};

    vblank_irq_d = vblank_irq_q;
    if (vblank_evt) begin
      if (irq_enable) begin
        vblank_irq_d = 1'b1;
      end
    end else if (irq_ack) begin
      vblank_irq_d = 1'b0;
    end
  end

  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= 9'd0;
      raw_line_q    <= 10'd0;
      rep_cnt_q     <= '0;
      y_cnt_q       <= 9'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vblank_irq_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      raw_line_q    <= raw_line_d;
      rep_cnt_q     <= rep_cnt_d;
      y_cnt_q       <= y_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vblank_irq_q  <= vblank_irq_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign current_x   = h_cnt_q;
  assign current_y   = y_cnt_q;
  assign next_x      = h_cnt_d;
  assign next_y      = y_cnt_d;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = ({1'b0, h_cnt_q} < GW) && ({1'b0, y_cnt_q} < GH);
  assign vblank      = raw_line_q >= V_VIS;
  assign vblank_irq  = vblank_irq_q;
  assign frame_count = frame_count_q;

endmodule
